// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared mode encodings, ELU table constants and vector packing helpers for act_layer
`ifndef ACT_DATA_LEN
`define ACT_DATA_LEN 8
`endif

package act_pkg;

  // Activation select encodings carried on the mode input
  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_ELU    = 2'd2,
    ACT_LEAKY  = 2'd3
  } act_mode_e;

  // ELU table works on fixed point with ELU_FRAC fraction bits: y = round(2^F * (exp(x/2^F) - 1)).
  // Below -ELU_SAT_MAG the result has settled to -2^F, so the table stops there.
  localparam int ELU_FRAC    = 3;
  localparam int ELU_SAT_MAG = 23;
  localparam int ELU_TBL_W   = ELU_FRAC + 2;

  // Bit offset of group g inside a packed GROUPS*LANES*DATA_LEN vector
  function automatic int group_lsb(input int g, input int lanes, input int data_len);
    return g * lanes * data_len;
  endfunction

  // Bit offset of lane l inside one packed group
  function automatic int lane_lsb(input int l, input int data_len);
    return l * data_len;
  endfunction

endpackage

// File: rtl/act_elu_lut.sv
// rtl/act_elu_lut.sv - combinational ELU lookup table, non-negative inputs pass through
module act_elu_lut
  import act_pkg::*;
#(
  parameter int DATA_LEN = `ACT_DATA_LEN
) (
  input  logic [DATA_LEN-1:0] x,
  output logic [DATA_LEN-1:0] y
);

  logic [DATA_LEN:0]           mag;
  logic [ELU_TBL_W-1:0]        idx;
  logic signed [ELU_TBL_W-1:0] tbl;

  // Index the table by |x| clamped to the saturation point, then sign-extend the entry
  always_comb begin
    mag = -{x[DATA_LEN-1], x};
    idx = '0;
    tbl = '0;
    y   = x;
    if (mag >= (DATA_LEN+1)'(ELU_SAT_MAG)) begin
      idx = ELU_TBL_W'(ELU_SAT_MAG);
    end else begin
      idx = mag[ELU_TBL_W-1:0];
    end
    case (idx) inside
      5'd0:           tbl = 5'sd0;
      5'd1:           tbl = -5'sd1;
      5'd2:           tbl = -5'sd2;
      [5'd3:5'd4]:    tbl = -5'sd3;
      [5'd5:5'd6]:    tbl = -5'sd4;
      [5'd7:5'd9]:    tbl = -5'sd5;
      [5'd10:5'd13]:  tbl = -5'sd6;
      [5'd14:5'd22]:  tbl = -5'sd7;
      default:        tbl = -5'sd8;
    endcase
    if (x[DATA_LEN-1]) begin
      y = {{(DATA_LEN-ELU_TBL_W){tbl[ELU_TBL_W-1]}}, tbl};
    end
  end

endmodule

// File: rtl/act_lane.sv
// rtl/act_lane.sv - one activation lane: issue register, mode mux, ELU table, LUT_LAT delay line (optional ACT_LEAKY_EN)
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_LEN    = `ACT_DATA_LEN,
  parameter int LUT_LAT     = 2,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_LEN-1:0] x,
  input  logic [1:0]          mode,
  output logic [DATA_LEN-1:0] y
);

  logic [DATA_LEN-1:0] x_r;
  act_mode_e           mode_r;
  logic [DATA_LEN-1:0] elu_y;
  logic [DATA_LEN-1:0] fn_y;
  logic [DATA_LEN-1:0] dly [LUT_LAT];

`ifndef ACT_LEAKY_EN
  // No leaky datapath in this build; the shift amount has no consumer
  localparam int unused_leaky_shift = LEAKY_SHIFT;
`endif

  // Issue stage: capture the element and mode of the group issued this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r    <= '0;
      mode_r <= ACT_BYPASS;
    end else begin
      x_r    <= x;
      mode_r <= act_mode_e'(mode);
    end
  end

  act_elu_lut #(
    .DATA_LEN(DATA_LEN)
  ) u_elu (
    .x(x_r),
    .y(elu_y)
  );

  // Mode mux; every path feeds the same delay line so latency is mode-independent
  always_comb begin
    fn_y = x_r;
    case (mode_r)
      ACT_RELU: begin
        if (x_r[DATA_LEN-1]) fn_y = '0;
      end
      ACT_ELU: fn_y = elu_y;
`ifdef ACT_LEAKY_EN
      ACT_LEAKY: begin
        if (x_r[DATA_LEN-1]) fn_y = $signed(x_r) >>> LEAKY_SHIFT;
      end
`endif
      default: fn_y = x_r;
    endcase
  end

  // LUT_LAT-deep delay line, the lane result leaves from its last stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LUT_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= fn_y;
      for (int i = 1; i < LUT_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign y = dly[LUT_LAT-1];

endmodule

// File: rtl/act_layer.sv
// rtl/act_layer.sv - vector activation layer, LANES lanes stepping through GROUPS groups (optional ACT_LEAKY_EN)
module act_layer
  import act_pkg::*;
#(
  parameter int DATA_LEN    = `ACT_DATA_LEN,
  parameter int LANES       = 12,
  parameter int GROUPS      = 32,
  parameter int LUT_LAT     = 2,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [1:0]                        mode,
  input  logic [GROUPS*LANES*DATA_LEN-1:0]  d,
  output logic                              valid,
  output logic [GROUPS*LANES*DATA_LEN-1:0]  q
);

  localparam int              GW   = LANES * DATA_LEN;
  localparam int              CW   = $clog2(GROUPS);
  localparam logic [CW-1:0]   LAST = CW'(GROUPS - 1);

  logic           running;
  logic [1:0]     mode_r;
  logic [1:0]     run_mode;
  logic [CW-1:0]  issue_cnt;
  logic           issue_done;
  logic [CW-1:0]  cap_cnt;
  logic           cap_done;
  logic [LUT_LAT:0] tag;
  logic           issue_now;
  logic           write_now;
  logic [GW-1:0]  grp_in;
  logic [GW-1:0]  grp_out;

  // Group 0 goes out on the very first load cycle, before mode_r has been loaded
  assign run_mode  = running ? mode_r : mode;
  assign issue_now = load && !issue_done;
  assign write_now = tag[LUT_LAT];

  // Select the input group addressed by the issue counter
  always_comb begin
    grp_in = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (issue_cnt == CW'(g)) grp_in = d[group_lsb(g, LANES, DATA_LEN) +: GW];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    act_lane #(
      .DATA_LEN   (DATA_LEN),
      .LUT_LAT    (LUT_LAT),
      .LEAKY_SHIFT(LEAKY_SHIFT)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .x   (grp_in[lane_lsb(l, DATA_LEN) +: DATA_LEN]),
      .mode(run_mode),
      .y   (grp_out[lane_lsb(l, DATA_LEN) +: DATA_LEN])
    );
  end

  // Run control: mode capture, saturating issue/capture counters, in-flight tags, valid
  always_ff @(posedge clk) begin
    if (rst) begin
      running    <= 1'b0;
      mode_r     <= '0;
      issue_cnt  <= '0;
      issue_done <= 1'b0;
      cap_cnt    <= '0;
      cap_done   <= 1'b0;
      tag        <= '0;
      valid      <= 1'b0;
    end else if (!load) begin
      running    <= 1'b0;
      issue_cnt  <= '0;
      issue_done <= 1'b0;
      cap_cnt    <= '0;
      cap_done   <= 1'b0;
      tag        <= '0;
      valid      <= 1'b0;
    end else begin
      running <= 1'b1;
      if (!running) mode_r <= mode;
      tag <= {tag[LUT_LAT-1:0], issue_now};
      if (issue_now) begin
        if (issue_cnt == LAST) issue_done <= 1'b1;
        else                   issue_cnt  <= issue_cnt + 1'b1;
      end
      if (write_now) begin
        if (cap_cnt == LAST) cap_done <= 1'b1;
        else                 cap_cnt  <= cap_cnt + 1'b1;
      end
      valid <= cap_done;
    end
  end

  // Write each finished group into its slot; all other groups hold their content
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load && write_now) begin
      for (int g = 0; g < GROUPS; g++) begin
        if (cap_cnt == CW'(g)) q[group_lsb(g, LANES, DATA_LEN) +: GW] <= grp_out;
      end
    end
  end

endmodule

// File: tb/tb_act_layer.sv
// tb/tb_act_layer.sv - randomized self-checking bench for act_layer against a behavioural model
`timescale 1ns/1ps
`ifndef ACT_DATA_LEN
`define ACT_DATA_LEN 8
`endif

module tb_act_layer;

  localparam int DL  = `ACT_DATA_LEN;
  localparam int LN  = 12;
  localparam int GR  = 32;
  localparam int LAT = 2;
  localparam int SH  = 3;
  localparam int GW  = LN * DL;
  localparam int W   = GR * GW;
  localparam real ELU_SCALE = 8.0;
`ifdef ACT_LEAKY_EN
  localparam int LEAKY_M64 = -8;
`else
  localparam int LEAKY_M64 = -64;
`endif

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         load = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [W-1:0] d    = '0;
  logic         valid;
  logic [W-1:0] q;

  int n_cmp = 0;
  int n_bad = 0;

  act_layer #(
    .DATA_LEN(DL), .LANES(LN), .GROUPS(GR), .LUT_LAT(LAT), .LEAKY_SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .mode(mode), .d(d), .valid(valid), .q(q)
  );

  always #5 clk = ~clk;

  // Activation as a mathematical function of a signed integer element
  function automatic int act_fn(input int m, input int x);
    int  res;
    real r;
    res = x;
    case (m)
      1: res = (x < 0) ? 0 : x;
      2: begin
        if (x < 0) begin
          r   = ELU_SCALE * $exp(real'(x) / ELU_SCALE);
          res = $rtoi(r + 0.5) - $rtoi(ELU_SCALE);
        end
      end
      3: begin
`ifdef ACT_LEAKY_EN
        if (x < 0) res = $rtoi($floor(real'(x) / real'(1 << SH)));
`endif
      end
      default: res = x;
    endcase
    return res;
  endfunction

  function automatic logic [GW-1:0] model_group(input int m, input logic [GW-1:0] xin);
    logic [GW-1:0]        r;
    logic signed [DL-1:0] xs;
    r = '0;
    for (int l = 0; l < LN; l++) begin
      xs = xin[l*DL +: DL];
      r[l*DL +: DL] = DL'(act_fn(m, int'(xs)));
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic check_q(input string nm, input logic [W-1:0] exp);
    bit shown;
    n_cmp++;
    if (q !== exp) begin
      n_bad++;
      shown = 1'b0;
      for (int g = 0; g < GR; g++) begin
        if (!shown && q[g*GW +: GW] !== exp[g*GW +: GW]) begin
          $display("FAIL %s group %0d: got %h want %h", nm, g, q[g*GW +: GW], exp[g*GW +: GW]);
          shown = 1'b1;
        end
      end
    end
  endtask

  // Behavioural model: a run started at edge S writes group k at edge S+k+LAT+1, valid from S+GR+LAT+1
  typedef struct { int due; int grp; logic [GW-1:0] val; } wr_t;
  wr_t          pend[$];
  logic [W-1:0] exp_q     = '0;
  logic         exp_valid = 1'b0;

  initial begin
    int edge_no;
    int m_start;
    int m_mode;
    int k;
    bit m_run;
    edge_no = 0;
    m_start = 0;
    m_mode  = 0;
    m_run   = 1'b0;
    forever begin
      @(posedge clk);
      edge_no++;
      if (rst) begin
        exp_q = '0; exp_valid = 1'b0; m_run = 1'b0; pend.delete();
      end else if (!load) begin
        exp_valid = 1'b0; m_run = 1'b0; pend.delete();
      end else begin
        if (!m_run) begin
          m_run = 1'b1; m_start = edge_no; m_mode = int'(mode);
        end
        k = edge_no - m_start;
        if (k < GR) pend.push_back('{due: edge_no + LAT + 1, grp: k, val: model_group(m_mode, d[k*GW +: GW])});
        while (pend.size() > 0 && pend[0].due == edge_no) begin
          exp_q[pend[0].grp*GW +: GW] = pend[0].val;
          void'(pend.pop_front());
        end
        exp_valid = (k >= GR + LAT + 1);
      end
      #1;
      check("valid", valid, exp_valid);
      check_q("q", exp_q);
    end
  end

  task automatic randomize_d();
    for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom;
  endtask

  // Count edges from the first load edge (c=0) and report the first one after which valid is high
  task automatic watch(input int ncyc, output int first);
    first = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #2;
      if (valid === 1'b1 && first < 0) first = c;
    end
    @(negedge clk);
  endtask

  initial begin
    int f;
    int f2;
    int len;
    int gap;

    // Hand-computed values pinning the model itself
    check("pin_elu_m1", act_fn(2, -1), -1);
    check("pin_elu_m3", act_fn(2, -3), -3);
    check("pin_elu_m13", act_fn(2, -13), -6);
    check("pin_elu_m14", act_fn(2, -14), -7);
    check("pin_elu_m23", act_fn(2, -23), -8);
    check("pin_elu_m100", act_fn(2, -100), -8);
    check("pin_elu_pos", act_fn(2, 5), 5);
    check("pin_relu_neg", act_fn(1, -5), 0);
    check("pin_relu_pos", act_fn(1, 7), 7);
    check("pin_leaky_m64", act_fn(3, -64), LEAKY_M64);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_valid", valid, 0);
    check_q("reset_q", '0);
    rst = 1'b0;
    @(negedge clk);

    // ELU on an all-positive ramp, load held high
    for (int i = 0; i < GR * LN; i++) d[i*DL +: DL] = DL'((i % 120) + 1);
    mode = 2'd2; load = 1'b1;
    watch(40, f);
    check("elu_valid_cycle", f, 35);
    check_q("elu_q_eq_d", d);
    load = 1'b0;
    @(posedge clk); #2;
    check("abort_after_done_valid", valid, 0);
    @(negedge clk);

    // ReLU with -5, 0, 7 in group 0
    randomize_d();
    d[0*DL +: DL] = DL'(-5); d[1*DL +: DL] = DL'(0); d[2*DL +: DL] = DL'(7);
    mode = 2'd1; load = 1'b1;
    watch(40, f);
    check("relu_valid_cycle", f, 35);
    check("relu_lane0", $signed(q[0*DL +: DL]), 0);
    check("relu_lane1", $signed(q[1*DL +: DL]), 0);
    check("relu_lane2", $signed(q[2*DL +: DL]), 7);
    load = 1'b0;
    @(negedge clk);

    // Mode 3 on x = -64
    randomize_d();
    d[0 +: DL] = DL'(-64);
    mode = 2'd3; load = 1'b1;
    watch(40, f);
    check("leaky_lane0", $signed(q[0 +: DL]), LEAKY_M64);
    load = 1'b0;
    @(negedge clk);

    // Abort at cycle 10, restart one cycle later
    randomize_d();
    mode = 2'd2; load = 1'b1;
    watch(10, f);
    load = 1'b0;
    @(posedge clk); #2;
    check("abort_valid", valid, 0);
    @(negedge clk);
    load = 1'b1;
    watch(40, f);
    check("restart_valid_cycle", f, 35);
    load = 1'b0;
    @(negedge clk);

    // Reset at cycle 20 of a run with load held high
    randomize_d();
    mode = 2'd1; load = 1'b1;
    watch(20, f);
    rst = 1'b1;
    @(posedge clk); #2;
    check("rst_mid_valid", valid, 0);
    check_q("rst_mid_q", '0);
    @(negedge clk);
    rst = 1'b0;
    watch(40, f);
    check("post_rst_valid_cycle", f, 35);
    load = 1'b0;
    @(negedge clk);

    // Mode change 0->1 at cycle 5 is ignored
    randomize_d();
    mode = 2'd0; load = 1'b1;
    watch(5, f);
    mode = 2'd1;
    watch(36, f2);
    check("mode_change_valid_cycle", f2, 30);
    check_q("mode_change_q_eq_d", d);
    load = 1'b0;
    @(negedge clk);

    // Random runs: d changes every cycle, mode wiggles mid-run, random aborts
    for (int r = 0; r < 10; r++) begin
      len  = (r % 2 == 0) ? 40 : $urandom_range(45, 3);
      gap  = $urandom_range(3, 1);
      mode = 2'($urandom_range(3, 0));
      load = 1'b1;
      for (int c = 0; c < len; c++) begin
        randomize_d();
        if ($urandom_range(3, 0) == 0) mode = 2'($urandom_range(3, 0));
        @(negedge clk);
      end
      load = 1'b0;
      repeat (gap) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
